// File: rtl/ysyx_24110006_axi_pkg.sv
// Shared AXI read encodings and the read-master FSM states.
// YSYX_24110006_AXI_RD_TIMEOUT_EN adds the DRAIN state used after an R-phase timeout.
package ysyx_24110006_axi_pkg;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_EXOKAY = 2'b01;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;

   localparam logic [1:0] SZ_B = 2'd0;
   localparam logic [1:0] SZ_H = 2'd1;
   localparam logic [1:0] SZ_W = 2'd2;

   typedef enum logic [2:0] {
      S_IDLE,
      S_AR,
      S_R,
`ifdef YSYX_24110006_AXI_RD_TIMEOUT_EN
      S_RSP,
      S_DRAIN
`else
      S_RSP
`endif
   } state_t;

endpackage

// File: rtl/ysyx_24110006_axi_read_master_if.sv
// Read-only AXI channel bundle (AR + R) shared by the read master and its slaves.
interface ysyx_24110006_axi_read_master_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic [ADDR_W-1:0] araddr;
   logic              arvalid;
   logic              arready;
   logic [DATA_W-1:0] rdata;
   logic [1:0]        rresp;
   logic              rvalid;
   logic              rready;

   modport master (
      output araddr, arvalid, rready,
      input  arready, rdata, rresp, rvalid
   );

   modport slave (
      input  araddr, arvalid, rready,
      output arready, rdata, rresp, rvalid
   );
endinterface

// File: rtl/ysyx_24110006_load_align.sv
// Lane-shifts a 32-bit read beat and sign/zero-extends byte or halfword loads.
module ysyx_24110006_load_align
   import ysyx_24110006_axi_pkg::*;
(
   input  logic [31:0] i_rdata,
   input  logic [1:0]  i_lane,
   input  logic [1:0]  i_size,
   input  logic        i_signed,
   output logic [31:0] o_data
);

   logic [31:0] w_shifted;

   // Misaligned halves/words are not trapped here; the shifted value passes through.
   always_comb begin
      w_shifted = i_rdata >> {i_lane, 3'b000};
      case (i_size)
         SZ_B:    o_data = {{24{i_signed & w_shifted[7]}}, w_shifted[7:0]};
         SZ_H:    o_data = {{16{i_signed & w_shifted[15]}}, w_shifted[15:0]};
         default: o_data = w_shifted;
      endcase
   end

endmodule

// File: rtl/ysyx_24110006_axi_read_master.sv
// Single-outstanding AXI read initiator: core load request -> one AR/R transaction -> aligned response.
// YSYX_24110006_AXI_RD_TIMEOUT_EN enables the R-phase watchdog and the DRAIN state.
module ysyx_24110006_axi_read_master
   import ysyx_24110006_axi_pkg::*;
#(
   parameter int ADDR_W      = 32,
   parameter int DATA_W      = 32,
   parameter int TIMEOUT_CYC = 1024
) (
   input  logic              i_clock,
   input  logic              i_reset,
   input  logic              i_req_valid,
   output logic              o_req_ready,
   input  logic [ADDR_W-1:0] i_req_addr,
   input  logic [1:0]        i_req_size,
   input  logic              i_req_signed,
   output logic              o_rsp_valid,
   input  logic              i_rsp_ready,
   output logic [31:0]       o_rsp_data,
   output logic              o_rsp_err,
   ysyx_24110006_axi_read_master_if.master out
);

   if (DATA_W != 32 || TIMEOUT_CYC < 2) begin : g_badParams
      $error("ysyx_24110006_axi_read_master: DATA_W must be 32 and TIMEOUT_CYC >= 2");
   end

   state_t            r_state,   w_state;
   logic [ADDR_W-1:0] r_araddr,  w_araddr;
   logic              r_arvalid, w_arvalid;
   logic              r_rready,  w_rready;
   logic [1:0]        r_size,    w_size;
   logic              r_signed,  w_signed;
   logic              r_rspValid, w_rspValid;
   logic [31:0]       r_rspData, w_rspData;
   logic              r_rspErr,  w_rspErr;
   logic [31:0]       w_aligned;

`ifdef YSYX_24110006_AXI_RD_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYC);
   logic [CNT_W-1:0] r_timeoutCnt, w_timeoutCnt;
   logic             r_timedOut,   w_timedOut;
`endif

   ysyx_24110006_load_align u_align (
      .i_rdata  (out.rdata),
      .i_lane   (r_araddr[1:0]),
      .i_size   (r_size),
      .i_signed (r_signed),
      .o_data   (w_aligned)
   );

   // Next-state and next-register values; everything holds unless a handshake moves it.
   always_comb begin
      w_state    = r_state;
      w_araddr   = r_araddr;
      w_arvalid  = r_arvalid;
      w_rready   = r_rready;
      w_size     = r_size;
      w_signed   = r_signed;
      w_rspValid = r_rspValid;
      w_rspData  = r_rspData;
      w_rspErr   = r_rspErr;
`ifdef YSYX_24110006_AXI_RD_TIMEOUT_EN
      w_timeoutCnt = r_timeoutCnt;
      w_timedOut   = r_timedOut;
`endif
      case (r_state)
         S_IDLE: begin
            if (i_req_valid) begin
               w_araddr  = i_req_addr;
               w_arvalid = 1'b1;
               w_size    = i_req_size;
               w_signed  = i_req_signed;
               w_state   = S_AR;
            end
         end
         S_AR: begin
            if (out.arready) begin
               w_arvalid = 1'b0;
               w_rready  = 1'b1;
               w_state   = S_R;
`ifdef YSYX_24110006_AXI_RD_TIMEOUT_EN
               w_timeoutCnt = '0;
`endif
            end
         end
         S_R: begin
            if (out.rvalid && r_rready) begin
               w_rready   = 1'b0;
               w_rspValid = 1'b1;
               w_rspData  = w_aligned;
               w_rspErr   = out.rresp[1];
               w_state    = S_RSP;
`ifdef YSYX_24110006_AXI_RD_TIMEOUT_EN
               w_timedOut = 1'b0;
            end else if (r_timeoutCnt == CNT_W'(TIMEOUT_CYC - 1)) begin
               w_rready   = 1'b0;
               w_rspValid = 1'b1;
               w_rspData  = '0;
               w_rspErr   = 1'b1;
               w_timedOut = 1'b1;
               w_state    = S_RSP;
            end else begin
               w_timeoutCnt = r_timeoutCnt + 1'b1;
`endif
            end
         end
         S_RSP: begin
            if (i_rsp_ready) begin
               w_rspValid = 1'b0;
               w_state    = S_IDLE;
`ifdef YSYX_24110006_AXI_RD_TIMEOUT_EN
               // A timed-out beat may still arrive; swallow it before taking new work.
               if (r_timedOut) begin
                  w_rready = 1'b1;
                  w_state  = S_DRAIN;
               end
`endif
            end
         end
`ifdef YSYX_24110006_AXI_RD_TIMEOUT_EN
         S_DRAIN: begin
            if (out.rvalid) begin
               w_rready = 1'b0;
               w_state  = S_IDLE;
            end
         end
`endif
         default: w_state = S_IDLE;
      endcase
   end

   // State and datapath registers with synchronous reset.
   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         r_state    <= S_IDLE;
         r_araddr   <= '0;
         r_arvalid  <= 1'b0;
         r_rready   <= 1'b0;
         r_size     <= SZ_W;
         r_signed   <= 1'b0;
         r_rspValid <= 1'b0;
         r_rspData  <= '0;
         r_rspErr   <= 1'b0;
`ifdef YSYX_24110006_AXI_RD_TIMEOUT_EN
         r_timeoutCnt <= '0;
         r_timedOut   <= 1'b0;
`endif
      end else begin
         r_state    <= w_state;
         r_araddr   <= w_araddr;
         r_arvalid  <= w_arvalid;
         r_rready   <= w_rready;
         r_size     <= w_size;
         r_signed   <= w_signed;
         r_rspValid <= w_rspValid;
         r_rspData  <= w_rspData;
         r_rspErr   <= w_rspErr;
`ifdef YSYX_24110006_AXI_RD_TIMEOUT_EN
         r_timeoutCnt <= w_timeoutCnt;
         r_timedOut   <= w_timedOut;
`endif
      end
   end

   assign o_req_ready = (r_state == S_IDLE);
   assign o_rsp_valid = r_rspValid;
   assign o_rsp_data  = r_rspData;
   assign o_rsp_err   = r_rspErr;
   assign out.araddr  = r_araddr;
   assign out.arvalid = r_arvalid;
   assign out.rready  = r_rready;

endmodule

// File: tb/tb_ysyx_24110006_axi_read_master.sv
// Directed bench for ysyx_24110006_axi_read_master with a configurable AXI read slave model.
// The timeout scenario runs only when YSYX_24110006_AXI_RD_TIMEOUT_EN is defined.
module tb_ysyx_24110006_axi_read_master;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        reqValid = 1'b0;
   logic        reqReady;
   logic [31:0] reqAddr = '0;
   logic [1:0]  reqSize = 2'd0;
   logic        reqSigned = 1'b0;
   logic        rspValid;
   logic        rspReady = 1'b0;
   logic [31:0] rspData;
   logic        rspErr;

   int errors = 0;
   int checks = 0;

   ysyx_24110006_axi_read_master_if #(.ADDR_W(32), .DATA_W(32)) axi ();

   ysyx_24110006_axi_read_master #(
      .ADDR_W(32),
      .DATA_W(32)
`ifdef YSYX_24110006_AXI_RD_TIMEOUT_EN
      , .TIMEOUT_CYC(8)
`endif
   ) dut (
      .i_clock      (clock),
      .i_reset      (reset),
      .i_req_valid  (reqValid),
      .o_req_ready  (reqReady),
      .i_req_addr   (reqAddr),
      .i_req_size   (reqSize),
      .i_req_signed (reqSigned),
      .o_rsp_valid  (rspValid),
      .i_rsp_ready  (rspReady),
      .o_rsp_data   (rspData),
      .o_rsp_err    (rspErr),
      .out          (axi)
   );

   always #5 clock = ~clock;

   // Slave model: arready after cfgArWait stalled cycles, one beat per AR handshake.
   int          cfgArWait = 0;
   logic        cfgRvalidEn = 1'b1;
   logic [31:0] cfgRdata = 32'h8765_4321;
   logic [1:0]  cfgRresp = 2'b00;
   int          arWaitCnt = 0;
   logic        rPending = 1'b0;
   int          arHsCount = 0;

   assign axi.arready = axi.arvalid && (arWaitCnt == 0);
   assign axi.rvalid  = rPending && cfgRvalidEn;
   assign axi.rdata   = cfgRdata;
   assign axi.rresp   = cfgRresp;

   always @(posedge clock) begin
      if (reset) begin
         rPending  <= 1'b0;
         arWaitCnt <= cfgArWait;
      end else begin
         if (!axi.arvalid) arWaitCnt <= cfgArWait;
         else if (arWaitCnt != 0) arWaitCnt <= arWaitCnt - 1;
         if (axi.arvalid && axi.arready) begin
            rPending  <= 1'b1;
            arHsCount <= arHsCount + 1;
         end else if (axi.rvalid && axi.rready) begin
            rPending <= 1'b0;
         end
      end
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   // Single comparison point for every check in the bench.
   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      if (observed !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
      end
   endtask

   // Issues one request and waits (bounded) for the response; reports latency and AR-valid cycles.
   task automatic applyStimulus(input logic [31:0] addr, input logic [1:0] size, input logic sgn,
                                output int latency, output int arCycles);
      @(negedge clock);
      checkOutput("reqReadyIdle", reqReady, 1);
      reqValid = 1'b1; reqAddr = addr; reqSize = size; reqSigned = sgn;
      @(negedge clock);
      reqValid = 1'b0;
      latency = 1;
      arCycles = 0;
      checkOutput("arvalidLatency", axi.arvalid, 1);
      checkOutput("araddr", axi.araddr, addr);
      while (!rspValid && latency < 50) begin
         if (axi.arvalid) begin
            arCycles++;
            checkOutput("araddrStable", axi.araddr, addr);
         end
         checkOutput("reqReadyBusy", reqReady, 0);
         @(negedge clock);
         latency++;
      end
      checkOutput("rspValidArrived", rspValid, 1);
   endtask

   // Holds the response for holdCycles, checking it is stable, then consumes it.
   task automatic consume(input logic [31:0] expData, input logic expErr, input int holdCycles,
                          input logic expReqReadyAfter);
      for (int i = 0; i <= holdCycles; i++) begin
         checkOutput("rspValidHeld", rspValid, 1);
         checkOutput("rspData", rspData, expData);
         checkOutput("rspErr", rspErr, expErr);
         checkOutput("reqReadyInRsp", reqReady, 0);
         checkOutput("rreadyInRsp", axi.rready, 0);
         if (i < holdCycles) @(negedge clock);
      end
      rspReady = 1'b1;
      @(negedge clock);
      rspReady = 1'b0;
      checkOutput("rspValidDropped", rspValid, 0);
      checkOutput("reqReadyAfterRsp", reqReady, expReqReadyAfter);
   endtask

   task automatic runVector(input logic [31:0] addr, input logic [1:0] size, input logic sgn,
                            input logic [31:0] expData, input logic expErr);
      int lat, arc;
      applyStimulus(addr, size, sgn, lat, arc);
      checkOutput("latency", lat, 3);
      checkOutput("arCycles", arc, 1);
      consume(expData, expErr, 0, 1'b1);
   endtask

   initial begin
      int lat, arc, hsBefore;

      repeat (3) @(negedge clock);
      checkOutput("rstArvalid", axi.arvalid, 0);
      checkOutput("rstAraddr", axi.araddr, 0);
      checkOutput("rstRready", axi.rready, 0);
      checkOutput("rstRspValid", rspValid, 0);
      checkOutput("rstRspData", rspData, 0);
      checkOutput("rstRspErr", rspErr, 0);
      checkOutput("rstReqReady", reqReady, 1);
      reset = 1'b0;

      // Alignment and extension against rdata 8765_4321.
      runVector(32'h0200_BFF8, 2'd2, 1'b0, 32'h8765_4321, 1'b0);
      runVector(32'h0200_BFF9, 2'd0, 1'b1, 32'h0000_0043, 1'b0);
      runVector(32'h0200_BFFB, 2'd0, 1'b1, 32'hFFFF_FF87, 1'b0);
      runVector(32'h0200_BFFA, 2'd1, 1'b0, 32'h0000_8765, 1'b0);
      runVector(32'h0200_BFFA, 2'd1, 1'b1, 32'hFFFF_8765, 1'b0);
      runVector(32'h0200_BFF8, 2'd1, 1'b1, 32'h0000_4321, 1'b0);
      runVector(32'h0200_BFF8, 2'd0, 1'b0, 32'h0000_0021, 1'b0);
      runVector(32'h0200_BFFB, 2'd0, 1'b0, 32'h0000_0087, 1'b0);

      // AR stalled 5 cycles: address held, one handshake, latency grows by 5.
      cfgArWait = 5;
      hsBefore = arHsCount;
      applyStimulus(32'h8000_0010, 2'd2, 1'b0, lat, arc);
      checkOutput("stallLatency", lat, 8);
      checkOutput("stallArCycles", arc, 6);
      checkOutput("stallHandshakes", arHsCount - hsBefore, 1);
      consume(32'h8765_4321, 1'b0, 0, 1'b1);
      cfgArWait = 0;

      // Error responses, with a held response on SLVERR.
      cfgRdata = 32'hDEAD_BEEF;
      cfgRresp = 2'b10;
      applyStimulus(32'h1000_0000, 2'd2, 1'b0, lat, arc);
      consume(32'hDEAD_BEEF, 1'b1, 4, 1'b1);
      cfgRresp = 2'b01;
      runVector(32'h1000_0002, 2'd1, 1'b0, 32'h0000_DEAD, 1'b0);
      cfgRresp = 2'b11;
      runVector(32'h1000_0001, 2'd0, 1'b1, 32'hFFFF_FFBE, 1'b1);
      cfgRresp = 2'b00;

      // Reset while in R with a beat pending.
      cfgRvalidEn = 1'b0;
      @(negedge clock);
      reqValid = 1'b1; reqAddr = 32'h2000_0004; reqSize = 2'd2; reqSigned = 1'b0;
      @(negedge clock);
      reqValid = 1'b0;
      @(negedge clock);
      checkOutput("inRready", axi.rready, 1);
      cfgRvalidEn = 1'b1;
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      checkOutput("midRstArvalid", axi.arvalid, 0);
      checkOutput("midRstRready", axi.rready, 0);
      checkOutput("midRstRspValid", rspValid, 0);
      checkOutput("midRstReqReady", reqReady, 1);
      runVector(32'h2000_0004, 2'd2, 1'b0, 32'hDEAD_BEEF, 1'b0);

`ifdef YSYX_24110006_AXI_RD_TIMEOUT_EN
      // Watchdog: no beat for 8 R cycles, then a late beat is drained.
      cfgRvalidEn = 1'b0;
      cfgRdata = 32'h1234_5678;
      applyStimulus(32'h3000_0000, 2'd2, 1'b0, lat, arc);
      checkOutput("timeoutLatency", lat, 10);
      consume(32'h0000_0000, 1'b1, 0, 1'b0);
      checkOutput("drainRready", axi.rready, 1);
      repeat (2) begin
         @(negedge clock);
         checkOutput("drainReqReady", reqReady, 0);
         checkOutput("drainNoRsp", rspValid, 0);
      end
      cfgRvalidEn = 1'b1;
      @(negedge clock);
      checkOutput("drainDoneReqReady", reqReady, 1);
      checkOutput("drainDoneRready", axi.rready, 0);
      checkOutput("drainDoneNoRsp", rspValid, 0);
      runVector(32'h3000_0000, 2'd2, 1'b0, 32'h1234_5678, 1'b0);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/ysyx_24110006_axi_read_master.md
Name: ysyx_24110006_axi_read_master

Overview:
- Single-outstanding AXI read initiator.
- Converts a simple valid/ready load request from the core (LSU/IFU side) into one AXIFULL_READ transaction, then returns an aligned, extended response.
- Drives the master side of the same AXIFULL_READ interface that CLINT/SRAM/UART slaves implement; sits between the core and the crossbar.

Parameters:
- ADDR_W, 32, request/AR address width
- DATA_W, 32, R data width; fixed at 32, other values unsupported
- TIMEOUT_CYC, 1024, R-phase watchdog limit in cycles (used only with the optional feature)

Ports:
- i_clock  in  1  clock
- i_reset  in  1  synchronous, active-high reset
- i_req_valid  in  1  load request valid
- o_req_ready  out  1  request accepted when high with i_req_valid
- i_req_addr  in  ADDR_W  byte address
- i_req_size  in  2  0=byte 1=half 2=word
- i_req_signed  in  1  sign-extend sub-word result
- o_rsp_valid  out  1  response valid, held until i_rsp_ready
- i_rsp_ready  in  1  consumer ready
- o_rsp_data  out  32  aligned/extended load data
- o_rsp_err  out  1  bus error or timeout
- out  modport  AXIFULL_READ.master  uses araddr, arvalid, arready, rdata, rresp, rvalid, rready

Behaviour:
- Clocking/reset: one clock i_clock; reset i_reset is synchronous, active-high.
- Reset values: state=IDLE, arvalid=0, araddr=0, rready=0, o_rsp_valid=0, o_rsp_data=0, o_rsp_err=0, o_req_ready=1.
- Reset asserted mid-transaction: unconditional return to IDLE; any in-flight beat is dropped.
- FSM states: IDLE, AR, R, RSP (+DRAIN with the optional feature).
- IDLE:
  - o_req_ready=1.
  - On i_req_valid: latch addr, size, signed; araddr<=addr; arvalid<=1; go to AR.
  - Request-to-arvalid latency: 1 cycle.
- AR:
  - arvalid held high; araddr stable until arvalid&&arready.
  - On handshake: arvalid<=0, rready<=1, go to R.
  - arready sampled already high (always-ready slave): handshake completes in the first AR cycle.
- R:
  - rready=1. On rvalid&&rready: rready<=0, capture the result, go to RSP.
  - A beat already valid on R entry is accepted in that cycle.
- RSP:
  - o_rsp_valid=1; data/err stable until i_rsp_ready.
  - On i_rsp_ready: o_rsp_valid<=0, go to IDLE.
  - No new request is accepted during RSP; o_req_ready=1 only in IDLE.
  - Minimum request-to-response: 3 cycles against a 1-cycle slave.
- Alignment: lane = addr[1:0].
  - shifted = rdata >> (lane*8).
  - Byte: bits[7:0]. Half: bits[15:0]. Word: rdata unmodified.
  - Extension: sign-extend if i_req_signed, else zero-extend.
  - Misaligned half (lane=3) / word (lane!=0): not checked; the shifted value is returned as-is.
- Error: o_rsp_err = rresp[1] (SLVERR/DECERR). rresp=2'b01 (EXOKAY) is treated as OK. o_rsp_data still carries the aligned rdata on error.
- Protocol rules:
  - arvalid never deasserts before arready.
  - rready is never asserted outside R/DRAIN.
  - At most one outstanding transaction.

Optional Feature:
- Macro: YSYX_24110006_AXI_RD_TIMEOUT_EN.
- Defined:
  - A counter clears on R entry and increments each R cycle without rvalid.
  - Reaching TIMEOUT_CYC-1 with no rvalid: go to RSP with o_rsp_err=1, o_rsp_data=0.
  - After that response is consumed, go to DRAIN (not IDLE).
  - DRAIN: rready=1, o_req_ready=0; the first rvalid is discarded, then go to IDLE.
  - rvalid arriving in the same cycle as expiry counts as normal completion; no timeout.
  - The AR phase is never timed out (AXI forbids arvalid withdrawal).
- Undefined: no counter, no DRAIN state; R waits indefinitely.

Decomposition:
- Shared package ysyx_24110006_axi_pkg:
  - rresp encodings OKAY/EXOKAY/SLVERR/DECERR
  - size encodings SZ_B/SZ_H/SZ_W
  - FSM state enum
- One sub-module: ysyx_24110006_load_align (combinational rdata, lane, size, signed -> data), reused by the LSU.

Test Plan:
- Always-ready slave returning rdata=32'h8765_4321, req addr=0x0200_BFF8 word: araddr=0x0200_BFF8 on the cycle after req; o_rsp_data=32'h8765_4321, err=0, rsp_valid 3 cycles after the req handshake.
- Same rdata, addr lane=1 byte signed -> 32'h0000_0043. Lane=3 byte signed -> 32'hFFFF_FF87. Lane=2 half unsigned -> 32'h0000_8765.
- Slave holds arready=0 for 5 cycles: arvalid and araddr are stable all 5 cycles; exactly one AR handshake occurs.
- rresp=2'b10 with rdata=0xDEAD_BEEF -> o_rsp_err=1, data=0xDEAD_BEEF. Hold i_rsp_ready=0 for 4 cycles: response stable, o_req_ready=0 throughout.
- Assert i_reset while in R with rvalid pending: next cycle arvalid=0, rready=0, o_rsp_valid=0, o_req_ready=1.
- With the macro and TIMEOUT_CYC=8, slave never drives rvalid: err response (data=0) in R's 8th cycle. A late rvalid is then drained silently. The next request completes normally.
